reg_writeback_unit: RTL
=======================

// Module: reg_writeback_unit
// PURPOSE
//   Write-side driver for the 16x16 register file's single write port.
//   Accepts results from the ALU and load channels (valid/ready) into one skid entry per channel.
//   Arbitrates one commit per cycle and drives registered write_en/add/data to the register file.
//   Keeps a per-register pending-write scoreboard so decode can stall on in-flight destinations.
// PARAMETERS
//   DATA_W  16  register data width
//   ADDR_W  4   register address width (2**ADDR_W registers)
//   CNT_W   2   per-register in-flight counter width (max 2**CNT_W-1 outstanding)
// PORTS
//   i_clk          in   1       clock, all state on posedge
//   i_reset        in   1       asynchronous reset, active-high
//   i_issue_valid  in   1       decode issues an instruction with a register destination
//   i_issue_add    in   ADDR_W  destination of issued instruction
//   o_issue_stall  out  1       counter of i_issue_add saturated; issue not accepted
//   i_alu_valid    in   1       ALU result valid
//   i_alu_add      in   ADDR_W  ALU destination
//   i_alu_data     in   DATA_W  ALU result
//   o_alu_ready    out  1       ALU result accepted this cycle when valid&ready
//   i_ld_valid/i_ld_add/i_ld_data/o_ld_ready   same as ALU channel, load path
//   o_write_en     out  1       register-file write enable (registered)
//   o_write_add    out  ADDR_W  register-file write address (registered)
//   o_write_data   out  DATA_W  register-file write data (registered)
//   o_pending      out  2**ADDR_W  bit r = counter[r]!=0
// BEHAVIOUR
//   Reset (async, i_reset=1): skid entries invalid, counters 0, rr pointer=LD.
//     Outputs: o_write_en=0, o_write_add=0, o_write_data=0, o_pending=0, readies=1, o_issue_stall=0.
//     A reset mid-operation discards buffered results; no write is emitted for them.
//   Skid: per channel, entry {v,add,data}.
//     o_x_ready = ~v_x | grant_x (combinational from state only, no valid->ready path).
//     On valid&ready the entry loads; otherwise an unselected entry holds.
//   Arbiter: at most one grant per cycle among valid entries.
//     Only one valid: grant it. Both valid: round-robin; grant != last granted channel.
//     After reset, a tie goes to ALU (pointer=LD).
//   Commit: grant at posedge N -> o_write_en=1 with add/data during cycle N+1.
//     The register file captures it on the negedge inside N+1; no grant -> o_write_en=0.
//     Latency: input accepted at edge N; earliest write visible in cycle N+2.
//     Sustained throughput is one write/cycle total; the two channels share it.
//   Scoreboard: CNT_W-bit counter per register.
//     +1 on accepted issue (i_issue_valid & ~o_issue_stall); -1 on commit of that address (grant).
//     Same-address issue and commit in one cycle: net 0.
//     o_issue_stall = i_issue_valid & counter[i_issue_add]==max & no commit to that address this cycle.
//     Commit when counter is 0 is a protocol error: counter stays 0 (sim assertion).
//   Both channels may target the same address; commit order = grant order, last write wins.
// STRUCTURE
//   Shared package cpu_pkg: DATA_W/ADDR_W constants, channel enum {CH_ALU, CH_LD}.
//   Sub-module wb_skid_entry (one per channel): valid/ready register slice with grant input.
//   Arbiter, commit register and scoreboard live in the top; est. 150-250 lines.
// TESTING
//   1 reset: assert i_reset mid-cycle -> all outputs 0 asynchronously, o_pending=0, readies=1.
//   2 single ALU: issue r5, ALU {5,16'hBEEF} at edge N -> o_write_en=1,add=5,data=BEEF in N+2.
//     o_pending[5] 1->0 at the commit edge.
//   3 contention: ALU {3,0x1111} and LD {4,0x2222} both valid for 4 cycles.
//     -> writes alternate ALU,LD,ALU,LD; the blocked channel sees ready=0.
//   4 scoreboard saturate: 3 issues to r7 with no commits -> 4th issue o_issue_stall=1.
//     Same cycle with an r7 commit -> no stall; counter stays 3.
//   5 same-address order: LD r2=0xAAAA accepted before ALU r2=0x5555.
//     -> writes emitted in grant order; the final o_write_data to r2=0x5555.
//   6 reset with both skids full -> no o_write_en after release; first new input is written normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the register write-back path.
//   CPU_DATA_W / CPU_ADDR_W / CPU_CNT_W : default data, address and
//                                          in-flight counter widths
//   channel_e                           : write-back source channel
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 4;
    localparam int CPU_CNT_W  = 2;

    typedef enum logic {
        CH_ALU = 1'b0,
        CH_LD  = 1'b1
    } channel_e;

endpackage

// File: rtl/wb_skid_entry.sv
// One-entry valid/ready register slice feeding the write-back arbiter.
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_valid/i_add/i_data    producer side result
//   o_ready                 producer handshake; depends on state and grant only
//   i_grant                 arbiter consumes the held entry this cycle
//   o_valid/o_add/o_data    held entry presented to the arbiter
module wb_skid_entry
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_add,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic              i_grant,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_add,
    output logic [DATA_W-1:0] o_data
);

    // The slot frees up in the same cycle it is granted, so a new result
    // can replace the outgoing one without a bubble.
    assign o_ready = ~o_valid | i_grant;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_add   <= '0;
            o_data  <= '0;
        end else if (i_valid && o_ready) begin
            o_valid <= 1'b1;
            o_add   <= i_add;
            o_data  <= i_data;
        end else if (i_grant) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side driver for the register file's single write port.
//   i_clk, i_reset                    clock, asynchronous active-high reset
//   i_issue_valid/i_issue_add         decode reserves a destination register
//   o_issue_stall                     destination counter full; issue refused
//   i_alu_valid/add/data, o_alu_ready ALU result channel
//   i_ld_valid/add/data,  o_ld_ready  load result channel
//   o_write_en/add/data               registered register-file write port
//   o_pending                         bit r set while register r has writes in flight
module reg_writeback_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int CNT_W  = CPU_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_issue_valid,
    input  logic [ADDR_W-1:0]    i_issue_add,
    output logic                 o_issue_stall,
    input  logic                 i_alu_valid,
    input  logic [ADDR_W-1:0]    i_alu_add,
    input  logic [DATA_W-1:0]    i_alu_data,
    output logic                 o_alu_ready,
    input  logic                 i_ld_valid,
    input  logic [ADDR_W-1:0]    i_ld_add,
    input  logic [DATA_W-1:0]    i_ld_data,
    output logic                 o_ld_ready,
    output logic                 o_write_en,
    output logic [ADDR_W-1:0]    o_write_add,
    output logic [DATA_W-1:0]    o_write_data,
    output logic [2**ADDR_W-1:0] o_pending
);

    localparam int               NREG    = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              alu_v, ld_v;
    logic [ADDR_W-1:0] alu_add, ld_add;
    logic [DATA_W-1:0] alu_data, ld_data;
    logic              grant_alu, grant_ld;
    logic              commit_en;
    logic [ADDR_W-1:0] commit_add;
    logic [DATA_W-1:0] commit_data;
    logic              issue_accept;
    channel_e          last_q;
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];

    wb_skid_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_alu_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_alu_valid),
        .i_add   (i_alu_add),
        .i_data  (i_alu_data),
        .o_ready (o_alu_ready),
        .i_grant (grant_alu),
        .o_valid (alu_v),
        .o_add   (alu_add),
        .o_data  (alu_data)
    );

    wb_skid_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ld_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_ld_valid),
        .i_add   (i_ld_add),
        .i_data  (i_ld_data),
        .o_ready (o_ld_ready),
        .i_grant (grant_ld),
        .o_valid (ld_v),
        .o_add   (ld_add),
        .o_data  (ld_data)
    );

    // Round-robin between the two held entries: on a tie the channel that
    // did not win last time goes first.
    // NOTE: every always_comb output gets a default before any condition,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant_alu   = 1'b0;
        grant_ld    = 1'b0;
        commit_add  = alu_add;
        commit_data = alu_data;
        if (alu_v && (!ld_v || last_q == CH_LD)) begin
            grant_alu = 1'b1;
        end else if (ld_v) begin
            grant_ld    = 1'b1;
            commit_add  = ld_add;
            commit_data = ld_data;
        end
    end

    assign commit_en = grant_alu | grant_ld;

    // A commit to the same register in this cycle frees a slot, so a full
    // counter does not block the issue.
    assign o_issue_stall = i_issue_valid && (cnt_q[i_issue_add] == CNT_MAX) &&
                           !(commit_en && commit_add == i_issue_add);
    assign issue_accept  = i_issue_valid && !o_issue_stall;

    // Increment and decrement are applied independently; a saturated counter
    // with both active wraps up and back down to the same value. A commit
    // against an empty counter leaves it at zero.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_accept && i_issue_add == ADDR_W'(r)) begin
                cnt_d[r] = cnt_d[r] + 1'b1;
            end
            if (commit_en && commit_add == ADDR_W'(r) && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_d[r] - 1'b1;
            end
        end
    end

    always_comb begin
        o_pending = '0;
        for (int r = 0; r < NREG; r++) begin
            o_pending[r] = (cnt_q[r] != '0);
        end
    end

    // NOTE: the counter array is a small register bank, not a RAM, so it is
    // cleared on reset; decode must never see stale pending bits.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Commit register; address/data hold when idle, only write_en drops.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_write_en   <= 1'b0;
            o_write_add  <= '0;
            o_write_data <= '0;
            last_q       <= CH_LD;
        end else begin
            o_write_en <= commit_en;
            if (commit_en) begin
                o_write_add  <= commit_add;
                o_write_data <= commit_data;
            end
            if (grant_alu) begin
                last_q <= CH_ALU;
            end else if (grant_ld) begin
                last_q <= CH_LD;
            end
        end
    end

    a_commit_has_issue : assert property (
        @(posedge i_clk) disable iff (i_reset)
        !(commit_en && cnt_q[commit_add] == '0)
    );

endmodule
